muldiv_seq: RTL



---
 rtl/muldiv_seq_if.sv | 28 ++
 rtl/muldiv_seq.sv | 130 +++++++++++++
 2 files changed

// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - Issue, HI/LO access and status bus between the pipeline and muldiv_seq
interface muldiv_seq_if #(
  parameter int W = 32
);
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] dataA;
  logic [W-1:0] dataB;
  logic         hilo_rd;
  logic [1:0]   hilo_wr;
  logic [W-1:0] wr_data;
  logic         flush;
  logic         busy;
  logic         done;
  logic         stall;
  logic [W-1:0] HI;
  logic [W-1:0] LO;

  modport master (
    output start, op, dataA, dataB, hilo_rd, hilo_wr, wr_data, flush,
    input  busy, done, stall, HI, LO
  );

  modport slave (
    input  start, op, dataA, dataB, hilo_rd, hilo_wr, wr_data, flush,
    output busy, done, stall, HI, LO
  );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - Iterative mult/div sequencer owning HI/LO, one shared shift-add/subtract datapath
module muldiv_seq #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  muldiv_seq_if.slave bus
);
  localparam int W  = ITER;
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opb_q, opb_d;
  logic           is_div_q, is_div_d;
  logic           qneg_q, qneg_d;
  logic           rneg_q, rneg_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           done_q, done_d;

  logic           sgn_in;
  logic [W-1:0]   mag_a, mag_b;
  logic [W:0]     mul_sum, div_diff;
  logic [2*W-1:0] mul_next, div_next, prod_fix;

  // acc holds {partial product, multiplier} for mult and {remainder, quotient} for div
  always_comb begin
    sgn_in   = ~bus.op[0];
    mag_a    = (sgn_in && bus.dataA[W-1]) ? -bus.dataA : bus.dataA;
    mag_b    = (sgn_in && bus.dataB[W-1]) ? -bus.dataB : bus.dataB;
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, opb_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
    div_diff = acc_q[2*W-1:W-1] - {1'b0, opb_q};
    div_next = div_diff[W] ? {acc_q[2*W-2:0], 1'b0}
                           : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
    prod_fix = qneg_q ? -acc_q : acc_q;
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.hilo_wr[1]) hi_d = bus.wr_data;
        if (bus.hilo_wr[0]) lo_d = bus.wr_data;
        if (bus.start && !bus.flush) begin
          is_div_d = bus.op[1];
          qneg_d   = sgn_in & (bus.dataA[W-1] ^ bus.dataB[W-1]);
          rneg_d   = sgn_in & bus.dataA[W-1];
          acc_d    = bus.op[1] ? {{W{1'b0}}, mag_a} : {{W{1'b0}}, mag_b};
          opb_d    = bus.op[1] ? mag_b : mag_a;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d   = is_div_q ? div_next : mul_next;
        count_d = count_q + CW'(1);
        if (count_q == LAST) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          lo_d = qneg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
          hi_d = rneg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
        end else begin
          hi_d = prod_fix[2*W-1:W];
          lo_d = prod_fix[W-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // An abandoned operation must not touch HI/LO; an IDLE mthi/mtlo still lands
    if (bus.flush) begin
      state_d = IDLE;
      count_d = '0;
      done_d  = 1'b0;
      if (state_q != IDLE) begin
        hi_d = hi_q;
        lo_d = lo_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;
  assign bus.stall = bus.busy & (bus.start | bus.hilo_rd | (|bus.hilo_wr));
  assign bus.HI    = hi_q;
  assign bus.LO    = lo_q;
endmodule
